// File: rtl/lut_m_loader_pkg.sv
// Shared CLB definitions for the LUT configuration loader: FSM states and
// the width helper for the chunk counter.
package lut_m_loader_pkg;

  typedef enum logic {
    LOAD   = 1'b0,
    COMMIT = 1'b1
  } state_t;

  // A counter for a single chunk still needs one bit so its port is legal.
  function automatic int cnt_width(input int chunks);
    return (chunks > 1) ? $clog2(chunks) : 1;
  endfunction

endpackage

// File: rtl/lut_m_loader_if.sv
// Configuration, patch and LUT-side signals of the loader, with the driver
// side (master) and the loader side (slave) as modports.
interface lut_m_loader_if #(
  parameter int INPUTS       = 4,
  parameter int MEM_SIZE     = 2 ** INPUTS,
  parameter int CONFIG_WIDTH = 4
);

  logic                    cfg_valid;
  logic [CONFIG_WIDTH-1:0] cfg_data;
  logic                    cfg_ready;
  logic                    cfg_abort;
  logic                    wr_valid;
  logic [INPUTS-1:0]       wr_addr;
  logic                    wr_data;
  logic                    wr_ready;
  logic [MEM_SIZE-1:0]     config_in;
  logic                    cen;
  logic [INPUTS-1:0]       waddr;
  logic                    data_in;
  logic                    write_en;
  logic                    busy;
  // Evaluation path of the attached LUT, so its contents stay observable.
  logic [INPUTS-1:0]       lut_in;
  logic                    lut_out;

  modport master (
    output cfg_valid, cfg_data, cfg_abort, wr_valid, wr_addr, wr_data, lut_in,
    input  cfg_ready, wr_ready, config_in, cen, waddr, data_in, write_en,
           busy, lut_out
  );

  modport slave (
    input  cfg_valid, cfg_data, cfg_abort, wr_valid, wr_addr, wr_data, lut_in,
    output cfg_ready, wr_ready, config_in, cen, waddr, data_in, write_en,
           busy, lut_out
  );

endinterface

// File: rtl/lut_m.sv
// Memory-based LUT: bulk load on cen, single-bit patch on write_en,
// combinational read addressed by lut_in.
module lut_m #(
  parameter int INPUTS   = 4,
  parameter int MEM_SIZE = 2 ** INPUTS
) (
  input  logic                cclk,
  input  logic [MEM_SIZE-1:0] config_in,
  input  logic                cen,
  input  logic [INPUTS-1:0]   waddr,
  input  logic                data_in,
  input  logic                write_en,
  input  logic [INPUTS-1:0]   lut_in,
  output logic                lut_out
);

  logic [MEM_SIZE-1:0] mem;

  always_ff @(posedge cclk) begin
    if (cen) begin
      mem <= config_in;
    end else if (write_en) begin
      mem[waddr] <= data_in;
    end
  end

  assign lut_out = mem[lut_in];

endmodule

// File: rtl/lut_m_loader_cfg_deser.sv
// Chunk deserializer: assembles CONFIG_WIDTH chunks into a MEM_SIZE shadow
// frame, chunk 0 at the LSBs, and tracks frame progress in cnt.
module cfg_deser
  import lut_m_loader_pkg::*;
#(
  parameter  int MEM_SIZE     = 16,
  parameter  int CONFIG_WIDTH = 4,
  localparam int CHUNKS       = MEM_SIZE / CONFIG_WIDTH,
  localparam int CW           = cnt_width(CHUNKS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    accept,
  input  logic                    clear,
  input  logic [CONFIG_WIDTH-1:0] data,
  output logic [CW-1:0]           cnt,
  output logic                    last,
  output logic [MEM_SIZE-1:0]     frame
);

  logic [CW-1:0]       cnt_q;
  logic [MEM_SIZE-1:0] shadow_q;

  // frame already contains the chunk being accepted this cycle, so the top
  // can commit the completed frame on the same edge as the last accept.
  always_comb begin
    frame = shadow_q;
    if (accept) begin
      frame[cnt_q*CONFIG_WIDTH +: CONFIG_WIDTH] = data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      shadow_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (accept) begin
      shadow_q <= frame;
      cnt_q    <= last ? '0 : cnt_q + 1'b1;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == CW'(CHUNKS - 1));

endmodule

// File: rtl/lut_m_loader.sv
// LUT configuration loader: streams frames into a shadow register, commits
// them with a one-cycle cen, and arbitrates single-bit patches between frames.
module lut_m_loader
  import lut_m_loader_pkg::*;
#(
  parameter int INPUTS       = 4,
  parameter int MEM_SIZE     = 2 ** INPUTS,
  parameter int CONFIG_WIDTH = 4
) (
  input logic            clk,
  input logic            rst_n,
  lut_m_loader_if.slave  bus
);

  localparam int CHUNKS = MEM_SIZE / CONFIG_WIDTH;
  localparam int CW     = cnt_width(CHUNKS);

  state_t              state_q;
  state_t              state_d;
  logic [CW-1:0]       cnt;
  logic                last;
  logic [MEM_SIZE-1:0] frame;
  logic                cfg_ready;
  logic                wr_ready;
  logic                cen;
  logic                chunk_acc;
  logic                patch_acc;
  logic                abort_load;
  logic [MEM_SIZE-1:0] config_q;
  logic [INPUTS-1:0]   waddr_q;
  logic                data_q;
  logic                write_en_q;

  cfg_deser #(
    .MEM_SIZE     (MEM_SIZE),
    .CONFIG_WIDTH (CONFIG_WIDTH)
  ) u_deser (
    .clk    (clk),
    .rst_n  (rst_n),
    .accept (chunk_acc),
    .clear  (abort_load),
    .data   (bus.cfg_data),
    .cnt    (cnt),
    .last   (last),
    .frame  (frame)
  );

  // Handshakes are gated by rst_n so nothing is offered while in reset; a
  // patch only wins between frames, and an abort swallows that cycle's chunk.
  always_comb begin
    state_d    = state_q;
    cfg_ready  = 1'b0;
    wr_ready   = 1'b0;
    cen        = 1'b0;
    chunk_acc  = 1'b0;
    patch_acc  = 1'b0;
    abort_load = 1'b0;
    case (state_q)
      LOAD: begin
        wr_ready   = rst_n && (cnt == '0);
        patch_acc  = wr_ready && bus.wr_valid;
        cfg_ready  = rst_n && !patch_acc;
        abort_load = bus.cfg_abort;
        chunk_acc  = cfg_ready && bus.cfg_valid && !bus.cfg_abort;
        if (chunk_acc && last) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        cen     = rst_n;
        state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= LOAD;
      config_q   <= '0;
      waddr_q    <= '0;
      data_q     <= 1'b0;
      write_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      write_en_q <= patch_acc;
      if (patch_acc) begin
        waddr_q <= bus.wr_addr;
        data_q  <= bus.wr_data;
      end
      if (chunk_acc && last) begin
        config_q <= frame;
      end
    end
  end

  assign bus.cfg_ready = cfg_ready;
  assign bus.wr_ready  = wr_ready;
  assign bus.config_in = config_q;
  assign bus.cen       = cen;
  assign bus.waddr     = waddr_q;
  assign bus.data_in   = data_q;
  assign bus.write_en  = write_en_q;
  assign bus.busy      = (cnt != '0) || (state_q == COMMIT);

  lut_m #(
    .INPUTS   (INPUTS),
    .MEM_SIZE (MEM_SIZE)
  ) u_lut (
    .cclk      (clk),
    .config_in (config_q),
    .cen       (cen),
    .waddr     (waddr_q),
    .data_in   (data_q),
    .write_en  (write_en_q),
    .lut_in    (bus.lut_in),
    .lut_out   (bus.lut_out)
  );

endmodule

// File: tb/tb_lut_m_loader.sv
// Directed bench for lut_m_loader: frames, gaps, patch arbitration, aborts
// and resets, with hand-computed expected values.
module tb_lut_m_loader;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  lut_m_loader_if #(.INPUTS(4), .MEM_SIZE(16), .CONFIG_WIDTH(4)) bus ();

  lut_m_loader #(.INPUTS(4), .MEM_SIZE(16), .CONFIG_WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_chunk(input logic [3:0] d);
    bus.cfg_valid = 1'b1;
    bus.cfg_data  = d;
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.cfg_valid = 1'b0; bus.cfg_data = '0; bus.cfg_abort = 1'b0;
    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = 1'b0; bus.lut_in = '0;
    tick();
    tick();
    checks++; if (bus.cfg_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_cfg_ready: got %b expected 0", bus.cfg_ready); end
    checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_wr_ready: got %b expected 0", bus.wr_ready); end
    checks++; if (bus.config_in !== 16'h0000) begin errors++; $display("[TB] FAIL rst_config_in: got %h expected 0000", bus.config_in); end
    checks++; if (bus.cen !== 1'b0) begin errors++; $display("[TB] FAIL rst_cen: got %b expected 0", bus.cen); end
    checks++; if (bus.write_en !== 1'b0) begin errors++; $display("[TB] FAIL rst_write_en: got %b expected 0", bus.write_en); end
    checks++; if (bus.waddr !== 4'h0 || bus.data_in !== 1'b0) begin errors++; $display("[TB] FAIL rst_patch_regs: got %h/%b expected 0/0", bus.waddr, bus.data_in); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b expected 0", bus.busy); end
    rst_n = 1'b1;
    #1;
    checks++; if (bus.cfg_ready !== 1'b1 || bus.wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL idle_ready: got %b/%b expected 1/1", bus.cfg_ready, bus.wr_ready); end
  endtask

  task automatic test_basic_frame();
    send_chunk(4'h1);
    send_chunk(4'h2);
    send_chunk(4'h3);
    checks++; if (bus.cen !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_pre_cen: got cen=%b busy=%b expected 0/1", bus.cen, bus.busy); end
    send_chunk(4'h4);
    checks++; if (bus.cen !== 1'b1) begin errors++; $display("[TB] FAIL basic_cen: got %b expected 1", bus.cen); end
    checks++; if (bus.config_in !== 16'h4321) begin errors++; $display("[TB] FAIL basic_config: got %h expected 4321", bus.config_in); end
    checks++; if (bus.cfg_ready !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_commit_flags: got ready=%b busy=%b expected 0/1", bus.cfg_ready, bus.busy); end
    tick();
    checks++; if (bus.cen !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_post: got cen=%b busy=%b expected 0/0", bus.cen, bus.busy); end
    checks++; if (bus.config_in !== 16'h4321) begin errors++; $display("[TB] FAIL basic_hold: got %h expected 4321", bus.config_in); end
    bus.lut_in = 4'd4;
    #1;
    checks++; if (bus.lut_out !== 1'b0) begin errors++; $display("[TB] FAIL basic_lut4: got %b expected 0", bus.lut_out); end
    bus.lut_in = 4'd5;
    #1;
    checks++; if (bus.lut_out !== 1'b1) begin errors++; $display("[TB] FAIL basic_lut5: got %b expected 1", bus.lut_out); end
  endtask

  task automatic test_gapped_frame();
    logic       pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [3:0] dat [4] = '{4'hF, 4'h0, 4'hA, 4'h5};
    int n = 0;
    for (int k = 0; k < 7; k++) begin
      bus.cfg_valid = pat[k];
      if (pat[k]) bus.cfg_data = dat[n];
      tick();
      if (pat[k]) n++;
      if (k < 6) begin
        checks++; if (bus.busy !== 1'b1 || bus.cen !== 1'b0) begin errors++; $display("[TB] FAIL gap_cycle%0d: got busy=%b cen=%b expected 1/0", k, bus.busy, bus.cen); end
      end else begin
        checks++; if (bus.cen !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL gap_commit: got cen=%b busy=%b expected 1/1", bus.cen, bus.busy); end
        checks++; if (bus.config_in !== 16'h5A0F) begin errors++; $display("[TB] FAIL gap_config: got %h expected 5a0f", bus.config_in); end
      end
    end
    bus.cfg_valid = 1'b0;
    tick();
    checks++; if (bus.cen !== 1'b0) begin errors++; $display("[TB] FAIL gap_single_cen: got %b expected 0", bus.cen); end
  endtask

  task automatic test_arbitration();
    bus.lut_in    = 4'd5;
    bus.wr_valid  = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 1'b1;
    bus.cfg_valid = 1'b1; bus.cfg_data = 4'h9;
    #1;
    checks++; if (bus.cfg_ready !== 1'b0 || bus.wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL arb_ready: got cfg=%b wr=%b expected 0/1", bus.cfg_ready, bus.wr_ready); end
    tick();
    bus.wr_valid = 1'b0;
    checks++; if (bus.write_en !== 1'b1 || bus.waddr !== 4'd5 || bus.data_in !== 1'b1) begin errors++; $display("[TB] FAIL arb_patch: got we=%b addr=%h d=%b expected 1/5/1", bus.write_en, bus.waddr, bus.data_in); end
    checks++; if (bus.busy !== 1'b0 || bus.config_in !== 16'h5A0F) begin errors++; $display("[TB] FAIL arb_no_chunk: got busy=%b cfg=%h expected 0/5a0f", bus.busy, bus.config_in); end
    #1;
    checks++; if (bus.cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL arb_ready_after: got %b expected 1", bus.cfg_ready); end
    tick();
    bus.cfg_valid = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.write_en !== 1'b0 || bus.waddr !== 4'd5) begin errors++; $display("[TB] FAIL arb_chunk_taken: got busy=%b we=%b addr=%h expected 1/0/5", bus.busy, bus.write_en, bus.waddr); end
    checks++; if (bus.lut_out !== 1'b1) begin errors++; $display("[TB] FAIL arb_lut_patched: got %b expected 1", bus.lut_out); end
    send_chunk(4'h1);
    send_chunk(4'h2);
    send_chunk(4'h3);
    checks++; if (bus.cen !== 1'b1 || bus.config_in !== 16'h3219) begin errors++; $display("[TB] FAIL arb_frame: got cen=%b cfg=%h expected 1/3219", bus.cen, bus.config_in); end
    tick();
  endtask

  task automatic test_patch_blocked();
    send_chunk(4'h1);
    send_chunk(4'h2);
    bus.wr_valid  = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = 1'b0;
    bus.cfg_valid = 1'b1; bus.cfg_data = 4'h3;
    #1;
    checks++; if (bus.wr_ready !== 1'b0 || bus.cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL blk_cnt2: got wr=%b cfg=%b expected 0/1", bus.wr_ready, bus.cfg_ready); end
    tick();
    bus.cfg_data = 4'h4;
    #1;
    checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("[TB] FAIL blk_cnt3: got %b expected 0", bus.wr_ready); end
    tick();
    bus.cfg_valid = 1'b0;
    #1;
    checks++; if (bus.wr_ready !== 1'b0 || bus.cen !== 1'b1 || bus.config_in !== 16'h4321) begin errors++; $display("[TB] FAIL blk_commit: got wr=%b cen=%b cfg=%h expected 0/1/4321", bus.wr_ready, bus.cen, bus.config_in); end
    tick();
    checks++; if (bus.wr_ready !== 1'b1 || bus.write_en !== 1'b0) begin errors++; $display("[TB] FAIL blk_released: got wr=%b we=%b expected 1/0", bus.wr_ready, bus.write_en); end
    tick();
    bus.wr_valid = 1'b0;
    checks++; if (bus.write_en !== 1'b1 || bus.waddr !== 4'd3 || bus.data_in !== 1'b0) begin errors++; $display("[TB] FAIL blk_patch: got we=%b addr=%h d=%b expected 1/3/0", bus.write_en, bus.waddr, bus.data_in); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic d [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      bus.wr_valid = 1'b1; bus.wr_addr = 4'(i + 1); bus.wr_data = d[i];
      tick();
      checks++; if (bus.write_en !== 1'b1 || bus.waddr !== 4'(i + 1) || bus.data_in !== d[i]) begin errors++; $display("[TB] FAIL b2b_%0d: got we=%b addr=%h d=%b expected 1/%0d/%b", i, bus.write_en, bus.waddr, bus.data_in, i + 1, d[i]); end
    end
    bus.wr_valid = 1'b0;
    tick();
    checks++; if (bus.write_en !== 1'b0 || bus.waddr !== 4'd3 || bus.data_in !== 1'b1) begin errors++; $display("[TB] FAIL b2b_hold: got we=%b addr=%h d=%b expected 0/3/1", bus.write_en, bus.waddr, bus.data_in); end
    checks++; if (bus.config_in !== 16'h4321) begin errors++; $display("[TB] FAIL b2b_config: got %h expected 4321", bus.config_in); end
  endtask

  task automatic test_abort();
    send_chunk(4'h1);
    send_chunk(4'h2);
    bus.cfg_valid = 1'b1; bus.cfg_data = 4'hE; bus.cfg_abort = 1'b1;
    tick();
    bus.cfg_valid = 1'b0; bus.cfg_abort = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.cen !== 1'b0 || bus.config_in !== 16'h4321) begin errors++; $display("[TB] FAIL abort_clear: got busy=%b cen=%b cfg=%h expected 0/0/4321", bus.busy, bus.cen, bus.config_in); end
    send_chunk(4'h8);
    send_chunk(4'h7);
    send_chunk(4'h6);
    checks++; if (bus.cen !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL abort_refill: got cen=%b busy=%b expected 0/1", bus.cen, bus.busy); end
    send_chunk(4'h5);
    checks++; if (bus.cen !== 1'b1 || bus.config_in !== 16'h5678) begin errors++; $display("[TB] FAIL abort_frame: got cen=%b cfg=%h expected 1/5678", bus.cen, bus.config_in); end
    bus.cfg_abort = 1'b1;
    tick();
    bus.cfg_abort = 1'b0;
    checks++; if (bus.cen !== 1'b0 || bus.busy !== 1'b0 || bus.config_in !== 16'h5678) begin errors++; $display("[TB] FAIL abort_in_commit: got cen=%b busy=%b cfg=%h expected 0/0/5678", bus.cen, bus.busy, bus.config_in); end
  endtask

  task automatic test_reset_mid_frame();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    send_chunk(4'h1);
    send_chunk(4'h2);
    send_chunk(4'h3);
    rst_n = 1'b0;
    bus.cfg_valid = 1'b1; bus.cfg_data = 4'h4;
    #1;
    checks++; if (bus.cfg_ready !== 1'b0 || bus.cen !== 1'b0) begin errors++; $display("[TB] FAIL midrst_during: got ready=%b cen=%b expected 0/0", bus.cfg_ready, bus.cen); end
    tick();
    bus.cfg_valid = 1'b0;
    checks++; if (bus.config_in !== 16'h0000 || bus.busy !== 1'b0 || bus.cen !== 1'b0) begin errors++; $display("[TB] FAIL midrst_after: got cfg=%h busy=%b cen=%b expected 0000/0/0", bus.config_in, bus.busy, bus.cen); end
    rst_n = 1'b1;
    send_chunk(4'hC);
    send_chunk(4'hD);
    send_chunk(4'hE);
    checks++; if (bus.cen !== 1'b0) begin errors++; $display("[TB] FAIL midrst_early_cen: got %b expected 0", bus.cen); end
    send_chunk(4'hF);
    checks++; if (bus.cen !== 1'b1 || bus.config_in !== 16'hFEDC) begin errors++; $display("[TB] FAIL midrst_reload: got cen=%b cfg=%h expected 1/fedc", bus.cen, bus.config_in); end
    tick();
    send_chunk(4'h1);
    send_chunk(4'h2);
    send_chunk(4'h3);
    send_chunk(4'h4);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.cen !== 1'b0) begin errors++; $display("[TB] FAIL commitrst_cen: got %b expected 0", bus.cen); end
    tick();
    checks++; if (bus.config_in !== 16'h0000) begin errors++; $display("[TB] FAIL commitrst_config: got %h expected 0000", bus.config_in); end
    rst_n = 1'b1;
    tick();
    checks++; if (bus.cen !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL commitrst_idle: got cen=%b busy=%b expected 0/0", bus.cen, bus.busy); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_frame();
    test_gapped_frame();
    test_arbitration();
    test_patch_blocked();
    test_back_to_back();
    test_abort();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lut_m_loader.md
LUT_M_LOADER -- requirements
Module: lut_m_loader

Interface
REQ-001 The block SHALL have parameter INPUTS, default 4, meaning the address width of the target memory LUT.
REQ-002 The block SHALL have parameter MEM_SIZE, default 2**INPUTS, meaning the number of configuration bits per frame.
REQ-003 The block SHALL have parameter CONFIG_WIDTH, default 4, meaning bits per accepted chunk; MEM_SIZE SHALL be a multiple of CONFIG_WIDTH.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset: clk  in  1  sole clock, all state on rising edge; rst_n  in  1  synchronous active-low reset.
REQ-005 The block SHALL have these ports:
- cfg_valid  in  1  chunk offered
- cfg_data  in  CONFIG_WIDTH  chunk payload
- cfg_ready  out  1  chunk accepted when high with cfg_valid
- cfg_abort  in  1  discard the partial frame
- wr_valid  in  1  single-bit patch request
- wr_addr  in  INPUTS  patch bit address
- wr_data  in  1  patch bit value
- wr_ready  out  1  patch accepted when high with wr_valid
- config_in  out  MEM_SIZE  block configuration to the LUT
- cen  out  1  one-cycle configuration strobe to the LUT
- waddr  out  INPUTS  patch address to the LUT
- data_in  out  1  patch data to the LUT
- write_en  out  1  one-cycle patch strobe to the LUT
- busy  out  1  frame in progress or commit pending

Function
REQ-006 The FSM SHALL have exactly two states: LOAD and COMMIT.
REQ-007 A chunk count cnt, ranging 0..MEM_SIZE/CONFIG_WIDTH-1 and sized with clog2 of the chunk count, SHALL track frame progress.
REQ-008 In LOAD, cfg_ready SHALL be 1 except when the patch wins arbitration (REQ-014); in COMMIT, cfg_ready SHALL be 0.
REQ-009 On each accepted chunk, cfg_data SHALL be written to shadow bits [cnt*CONFIG_WIDTH +: CONFIG_WIDTH] and cnt SHALL increment, so chunk 0 lands at the LSBs.
REQ-010 Acceptance of the last chunk SHALL move the FSM to COMMIT and wrap cnt to 0.
REQ-011 For exactly one cycle in COMMIT, cen SHALL be 1 and config_in SHALL take the full shadow value; the FSM SHALL then return to LOAD.
REQ-012 config_in SHALL change only on commit and SHALL hold its value otherwise; cen latency SHALL be exactly 1 cycle after the last accepted chunk.
REQ-013 wr_ready SHALL be 1 only in LOAD with cnt==0, so patches are never interleaved inside a frame.
REQ-014 When cnt==0 in LOAD and wr_valid and cfg_valid are both 1, the patch SHALL win, and cfg_ready SHALL be 0 that cycle.
REQ-015 An accepted patch SHALL register waddr=wr_addr and data_in=wr_data, and SHALL assert write_en for exactly the next cycle.
REQ-016 waddr and data_in SHALL hold their values between patches.
REQ-017 Patches SHALL sustain one per cycle back-to-back.
REQ-018 A patch SHALL NOT modify the shadow register or config_in.
REQ-019 cfg_abort in LOAD SHALL clear cnt to 0, accept no chunk that cycle, and produce no cen.
REQ-020 cfg_abort in COMMIT SHALL be ignored, and the commit SHALL complete.
REQ-021 busy SHALL be 1 when cnt!=0 or the state is COMMIT.

Reset
REQ-022 With rst_n=0 at a rising clk edge, the block SHALL reset to: state LOAD, cnt=0, shadow=0, config_in=0, cen=0, write_en=0, waddr=0, data_in=0.
REQ-023 Reset mid-frame or in COMMIT SHALL discard the partial frame and emit no cen.
REQ-024 While rst_n=0, cfg_ready and wr_ready SHALL be 0.

Structure
REQ-025 The state enum and the chunk-count width function SHALL live in the shared clb package.
REQ-026 The chunk deserializer (shadow register plus cnt) SHALL be a single sub-module named cfg_deser; the FSM, arbitration and patch registers SHALL stay at the top level.
REQ-027 Outputs SHALL connect directly to an lut_m instance whose cclk is tied to clk.

Verification
REQ-028 With INPUTS=4, CONFIG_WIDTH=4 and chunks 0x1,0x2,0x3,0x4 on consecutive cycles, the bench SHALL check config_in=16'h4321 and cen=1 exactly 1 cycle after the 4th accept.
REQ-029 With cfg_valid toggled 1,0,0,1,1,0,1 and chunks 0xF,0x0,0xA,0x5, the bench SHALL check config_in=16'h5A0F, a single cen pulse, and busy=1 throughout.
REQ-030 With wr_valid and cfg_valid both 1 at cnt==0 (wr_addr=5, wr_data=1), the bench SHALL check write_en=1, waddr=5 and data_in=1 next cycle, cfg_ready=0, and the chunk accepted the following cycle.
REQ-031 With wr_valid=1 at cnt==2, the bench SHALL check wr_ready=0 until the frame commits, then the patch is accepted.
REQ-032 With cfg_abort after 2 chunks followed by a fresh 4-chunk frame 0x8,0x7,0x6,0x5, the bench SHALL check config_in=16'h5678 and exactly one cen.
REQ-033 With rst_n=0 asserted after 3 chunks, the bench SHALL check no cen, config_in unchanged at 0, and that the next full frame loads correctly.
